wbrd2axil: RTL and testbench
============================

// Module: wbrd2axil
// PURPOSE
//  Pipelined Wishbone read slave bridged onto an AXI-lite read master (AR/R channels).
//  Lets a WB-only master (CPU, DMA) read from AXI-lite peripherals.
//  Keeps up to 2^LGFIFO reads in flight; responses return in order as WB ack/err.
//  Sits between the WB interconnect and an AXI-lite crossbar port.
// PARAMETERS
//  C_AXI_ADDR_WIDTH  28     AXI byte-address width
//  C_AXI_DATA_WIDTH  32     data width, fixed
//  AW                C_AXI_ADDR_WIDTH-2 (localparam): WB word-address width
//  LGFIFO            3      log2 of max outstanding reads
//  OPT_PROT          3'b000 constant driven on o_axi_arprot
// PORTS
//  i_clk          in   1   clock
//  w_reset        in   1   synchronous, active-high reset
//  i_wb_cyc       in   1   WB cycle
//  i_wb_stb       in   1   WB strobe
//  i_wb_we        in   1   WB write enable (used only with WBRD2AXIL_WE_ERR_EN)
//  i_wb_addr      in   AW  WB word address
//  o_wb_stall     out  1   WB stall
//  o_wb_ack       out  1   WB ack (registered)
//  o_wb_data      out  32  WB read data, valid with o_wb_ack
//  o_wb_err       out  1   WB bus error (registered)
//  o_axi_arvalid  out  1   AR valid
//  i_axi_arready  in   1   AR ready
//  o_axi_araddr   out  C_AXI_ADDR_WIDTH  {addr,2'b00}
//  o_axi_arprot   out  3   OPT_PROT
//  i_axi_rvalid   in   1   R valid
//  o_axi_rready   out  1   R ready, constant 1
//  i_axi_rdata    in   32  R data
//  i_axi_rresp    in   2   R response; rresp[1] set = SLVERR/DECERR
// BEHAVIOUR
//  Reset: o_axi_arvalid=0, o_wb_ack=0, o_wb_err=0, npending=0, state=IDLE; araddr/data regs hold.
//  Accept: i_wb_stb && !o_wb_stall && i_wb_cyc -> next cycle arvalid=1,
//   araddr={i_wb_addr,2'b00}; npending+1.
//  AR handshake: arvalid held with stable araddr until arready. Back-to-back accept allowed
//   on the cycle of the handshake.
//  o_wb_stall = (arvalid && !arready) || npending==2^LGFIFO || state!=ACTIVE(cyc seen).
//  R: rready=1. Each rvalid: npending-1 (same cycle as accept -> unchanged). Width LGFIFO+1, no wrap.
//  ACTIVE && rvalid: rresp[1]=0 -> o_wb_ack=1, o_wb_data=rdata, next cycle (1-cycle latency);
//   rresp[1]=1 -> o_wb_err=1, no ack; state->FLUSH.
//  Minimum latency WB stb -> ack: 2 cycles + AXI slave latency.
//  States: IDLE (npending=0, no cyc) -> ACTIVE on accept; ACTIVE -> IDLE when npending
//   reaches 0; ACTIVE -> FLUSH on !i_wb_cyc with npending!=0, or on error response.
//  FLUSH: stall=1, arvalid still held until its handshake, remaining R beats consumed and
//   discarded (no ack/err); -> IDLE when npending==0 and !arvalid.
//  ack/err forced 0 when !i_wb_cyc. Simultaneous err + cyc drop: FLUSH, err suppressed.
//  Reset mid-transaction: all state cleared same edge; late R beats while IDLE are ignored.
// CONFIGURATION
//  WBRD2AXIL_WE_ERR_EN defined: a request with i_wb_we=1 stalls until npending==0, then is
//   accepted without an AXI transaction; o_wb_err=1 next cycle.
//  Not defined: i_wb_we ignored (unused), every request treated as a read.
// STRUCTURE
//  Shared package: AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants, state enum
//   {IDLE,ACTIVE,FLUSH}.
//  No sub-module: AR holding register and pending counter inline. No data FIFO, since rready=1
//   and WB acks never stall.
// TESTING
//  Single read 0x100, arready=1, rdata=0xDEADBEEF OKAY -> araddr=0x400, ack+data 2 cycles later.
//  8 back-to-back stb, R delayed -> 9th stalls at npending=8, 8 acks in order.
//  arready low 5 cycles -> arvalid/araddr stable, stall=1 throughout, single handshake.
//  3 reads, 2nd rresp=2'b10 -> ack, err, then 3rd beat discarded; IDLE after.
//  cyc drops with 4 pending -> no ack/err, stall until 4 R beats, IDLE.
//  With _EN: write while 2 pending -> stall until 0, then err 1 cycle, no arvalid.

Source files
------------

// File: rtl/wbrd2axil_pkg.sv
// ----------------------------------------------------------------------------
// wbrd2axil_pkg
//
// Shared definitions for the Wishbone-read to AXI-lite-read bridge:
//   - AXI-lite response codes as carried on RRESP
//   - bridge state encoding (IDLE / ACTIVE / FLUSH)
//   - a helper that classifies an RRESP value as an error
//
// The only optional feature of the bridge is selected by the macro
// WBRD2AXIL_WE_ERR_EN (see wbrd2axil.sv); nothing here depends on it.
// ----------------------------------------------------------------------------
package wbrd2axil_pkg;

    // AXI-lite response codes. Bit 1 set means the slave (SLVERR) or the
    // interconnect (DECERR) refused the access.
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Bridge state.
    //   IDLE   : nothing outstanding, no bus cycle in progress
    //   ACTIVE : reads outstanding, responses returned as WB ack/err
    //   FLUSH  : bus cycle abandoned (cyc dropped or error seen); the
    //            remaining R beats are drained and thrown away
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } wbrd_state_t;

    // Any response with bit 1 set (SLVERR/DECERR) is a bus error.
    function automatic logic resp_is_err(input logic resp_hi);
        return resp_hi;
    endfunction

endpackage : wbrd2axil_pkg

// File: rtl/wbrd2axil.sv
// ----------------------------------------------------------------------------
// wbrd2axil
//
// Pipelined Wishbone read slave bridged onto an AXI-lite read master
// (AR and R channels only). Up to 2**LGFIFO reads may be in flight; AXI-lite
// returns read data in order, so each R beat maps directly onto the oldest
// outstanding WB request and no data FIFO is needed (rready is tied high and
// the WB ack path never stalls).
//
// Optional feature (macro WBRD2AXIL_WE_ERR_EN):
//   defined     : a WB write request waits until nothing is outstanding, is
//                 then accepted without any AXI transaction and answered with
//                 o_wb_err on the following cycle.
//   not defined : i_wb_we is ignored and every request is a read.
//
// Ports
//   i_clk          clock
//   w_reset        synchronous, active-high reset
//   i_wb_cyc       WB bus cycle
//   i_wb_stb       WB strobe
//   i_wb_we        WB write enable (only used with WBRD2AXIL_WE_ERR_EN)
//   i_wb_addr      WB word address (AW bits)
//   o_wb_stall     WB stall (combinational)
//   o_wb_ack       WB ack, registered
//   o_wb_data      WB read data, valid with o_wb_ack
//   o_wb_err       WB bus error, registered
//   o_axi_arvalid  AR valid
//   i_axi_arready  AR ready
//   o_axi_araddr   AR byte address = {word address, 2'b00}
//   o_axi_arprot   AR protection, constant OPT_PROT
//   i_axi_rvalid   R valid
//   o_axi_rready   R ready, constant 1
//   i_axi_rdata    R data
//   i_axi_rresp    R response (bit 1 set = SLVERR/DECERR)
// ----------------------------------------------------------------------------
module wbrd2axil
    import wbrd2axil_pkg::*;
#(
    parameter int         C_AXI_ADDR_WIDTH = 28,
    parameter int         C_AXI_DATA_WIDTH = 32,
    parameter int         LGFIFO           = 3,
    parameter logic [2:0] OPT_PROT         = 3'b000,
    localparam int        AW               = C_AXI_ADDR_WIDTH - 2
) (
    input  logic                        i_clk,
    input  logic                        w_reset,

    input  logic                        i_wb_cyc,
    input  logic                        i_wb_stb,
    input  logic                        i_wb_we,
    input  logic [AW-1:0]               i_wb_addr,
    output logic                        o_wb_stall,
    output logic                        o_wb_ack,
    output logic [C_AXI_DATA_WIDTH-1:0] o_wb_data,
    output logic                        o_wb_err,

    output logic                        o_axi_arvalid,
    input  logic                        i_axi_arready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
    output logic [2:0]                  o_axi_arprot,

    input  logic                        i_axi_rvalid,
    output logic                        o_axi_rready,
    input  logic [C_AXI_DATA_WIDTH-1:0] i_axi_rdata,
    input  logic [1:0]                  i_axi_rresp
);

    // Counter is one bit wider than LGFIFO so "full" (2**LGFIFO) is
    // representable; it never wraps because requests stall at full.
    localparam logic [LGFIFO:0] MAX_PENDING = {1'b1, {LGFIFO{1'b0}}};

    wbrd_state_t     state;
    logic [LGFIFO:0] npending;
    logic [LGFIFO:0] npending_next;

    logic            wb_accept;     // WB request taken this cycle
    logic            rd_accept;     // ... and it becomes an AXI read
    logic            wr_accept;     // ... and it is a rejected write
    logic            rd_return;     // an R beat matched to an outstanding read
    logic            rd_error;      // that beat carries SLVERR/DECERR
    logic            we_block;      // write waiting for the pipeline to empty

    assign o_axi_arprot = OPT_PROT;
    assign o_axi_rready = 1'b1;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
`ifdef WBRD2AXIL_WE_ERR_EN
    assign we_block = i_wb_we && (npending != '0);
`else
    assign we_block = 1'b0;
`endif

    // A held AR beat only blocks a new request until the cycle it is
    // handshaken, so back-to-back requests flow at one per clock.
    always_comb begin
        o_wb_stall = (o_axi_arvalid && !i_axi_arready)
                  || (npending == MAX_PENDING)
                  || (state == FLUSH)
                  || we_block;
    end

    assign wb_accept = i_wb_cyc && i_wb_stb && !o_wb_stall;

`ifdef WBRD2AXIL_WE_ERR_EN
    assign rd_accept = wb_accept && !i_wb_we;
    assign wr_accept = wb_accept &&  i_wb_we;
`else
    assign rd_accept = wb_accept;
    assign wr_accept = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // Beats arriving with nothing outstanding (e.g. stragglers from before
    // a reset) are ignored rather than letting the counter underflow.
    assign rd_return = i_axi_rvalid && (npending != '0);
    assign rd_error  = rd_return && resp_is_err(i_axi_rresp[1]);

    // NOTE: every signal assigned in an always_comb gets a default first,
    //       otherwise the untaken branches infer a latch.
    always_comb begin
        npending_next = npending;
        if (rd_accept && !rd_return)
            npending_next = npending + 1'b1;
        else if (!rd_accept && rd_return)
            npending_next = npending - 1'b1;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only, so every
    //       register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (w_reset) begin
            state         <= IDLE;
            npending      <= '0;
            o_axi_arvalid <= 1'b0;
            o_wb_ack      <= 1'b0;
            o_wb_err      <= 1'b0;
        end else begin
            npending <= npending_next;

            // AR valid rises on accept and stays up until the handshake;
            // an accept on the handshake cycle keeps it up for the next beat.
            if (rd_accept)
                o_axi_arvalid <= 1'b1;
            else if (i_axi_arready)
                o_axi_arvalid <= 1'b0;

            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (rd_accept)
                        state <= ACTIVE;
                end

                ACTIVE: begin
                    // Responses only reach a master that still owns the bus.
                    if (rd_return && i_wb_cyc) begin
                        o_wb_ack <= !rd_error;
                        o_wb_err <=  rd_error;
                    end

                    // An error abandons the rest of the burst, even when the
                    // master drops cyc in the same cycle (err then suppressed).
                    if (rd_error)
                        state <= FLUSH;
                    else if (npending_next == '0)
                        state <= IDLE;
                    else if (!i_wb_cyc)
                        state <= FLUSH;
                end

                FLUSH: begin
                    if ((npending == '0) && !o_axi_arvalid)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase

            // Rejected write: no AXI traffic, just an error strobe.
            if (wr_accept)
                o_wb_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: address and data registers carry no reset; they are qualified
    //       by arvalid/ack, which are reset, so their contents never matter
    //       until they have been loaded.
    always_ff @(posedge i_clk) begin
        if (rd_accept)
            o_axi_araddr <= {i_wb_addr, 2'b00};
    end

    always_ff @(posedge i_clk) begin
        if (rd_return && (state == ACTIVE))
            o_wb_data <= i_axi_rdata;
    end

    // Inputs that carry no information for this configuration.
    logic unused_inputs;
`ifdef WBRD2AXIL_WE_ERR_EN
    assign unused_inputs = &{1'b0, i_axi_rresp[0]};
`else
    assign unused_inputs = &{1'b0, i_axi_rresp[0], i_wb_we};
`endif

endmodule : wbrd2axil

// File: tb/tb_wbrd2axil.sv
// ----------------------------------------------------------------------------
// tb_wbrd2axil
//
// Cycle-level bench for wbrd2axil. A single process plays WB master and
// AXI-lite slave. The reference model tracks, in plain counters and a queue,
// what the bridge owes: how many reads are outstanding, whether the current
// burst has been abandoned, which AR beat is waiting, and which read each R
// beat belongs to. Outputs are checked every cycle, one time unit after the
// inputs settle and on the falling edge after each rising edge.
// Build with +define+WBRD2AXIL_WE_ERR_EN to also cover the write-reject path.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbrd2axil;

    localparam int AWID  = 28;
    localparam int WAW   = AWID - 2;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             w_reset = 1'b1;
    logic             cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [WAW-1:0]   addr = '0;
    logic             stall, ack, err;
    logic [31:0]      wb_data;
    logic             arvalid, arready = 1'b0;
    logic [AWID-1:0]  araddr;
    logic [2:0]       arprot;
    logic             rvalid = 1'b0, rready;
    logic [31:0]      rdata = '0;
    logic [1:0]       rresp = '0;

    always #5 clk = ~clk;

    wbrd2axil dut (
        .i_clk        (clk),
        .w_reset      (w_reset),
        .i_wb_cyc     (cyc),
        .i_wb_stb     (stb),
        .i_wb_we      (we),
        .i_wb_addr    (addr),
        .o_wb_stall   (stall),
        .o_wb_ack     (ack),
        .o_wb_data    (wb_data),
        .o_wb_err     (err),
        .o_axi_arvalid(arvalid),
        .i_axi_arready(arready),
        .o_axi_araddr (araddr),
        .o_axi_arprot (arprot),
        .i_axi_rvalid (rvalid),
        .o_axi_rready (rready),
        .i_axi_rdata  (rdata),
        .i_axi_rresp  (rresp)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AWID-1:0] addr;
        logic [1:0]      resp;
    } req_t;

    req_t            sq[$];        // AR beats accepted by the slave, awaiting R
    bit              m_arv = 0;    // an AR beat is waiting for its handshake
    logic [AWID-1:0] m_araddr = '0;
    int              m_pend = 0;   // reads owed by the bridge
    bit              m_flush = 0;  // burst abandoned, beats are discarded

    bit r_en = 0, r_always = 0, ar_rand = 0, ar_force = 0;
    bit last_accept = 0;
    int ack_cnt = 0, err_cnt = 0, hs_cnt = 0, cyc_cnt = 0;

    function automatic logic [31:0] data_for(input logic [AWID-1:0] a);
        if (a == 28'h400) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // Byte addresses 0xE000-0xEFFF (mod 64K) are an error region.
    function automatic logic [1:0] resp_for(input logic [AWID-1:0] a);
        if (a[15:12] == 4'hE) return $urandom_range(0, 1) ? 2'b10 : 2'b11;
        return $urandom_range(0, 1) ? 2'b00 : 2'b01;
    endfunction

    function automatic logic [WAW-1:0] rand_addr(input bit allow_err);
        logic [WAW-1:0] a;
        a = WAW'($urandom);
        if (a[13:10] == 4'hE) a[13:10] = 4'h3;
        if (allow_err && ($urandom_range(0, 7) == 0)) a[13:10] = 4'hE;
        return a;
    endfunction

    // One clock: drive slave inputs, check settled outputs, predict and
    // check what the rising edge produces.
    task automatic cycle();
        bit   exp_stall, acc, is_wr, hs, rb, nack, nerr, flush_n;
        logic [31:0] ndata;
        int   pend_n;

        arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'(ar_force);
        if (r_en && (sq.size() > 0) && (r_always || ($urandom_range(0, 3) != 0))) begin
            rvalid = 1'b1;
            rdata  = data_for(sq[0].addr);
            rresp  = sq[0].resp;
        end else begin
            rvalid = 1'b0;
            rdata  = $urandom;
            rresp  = 2'($urandom);
        end
        #1;

        exp_stall = (m_arv && !arready) || (m_pend == DEPTH) || m_flush;
`ifdef WBRD2AXIL_WE_ERR_EN
        if (we && (m_pend != 0)) exp_stall = 1'b1;
`endif
        check("stall", stall, exp_stall);
        check("arvalid", arvalid, m_arv);
        if (m_arv) check("araddr", araddr, m_araddr);

        acc   = stb && cyc && !exp_stall;
        is_wr = 1'b0;
`ifdef WBRD2AXIL_WE_ERR_EN
        is_wr = we;
`endif
        hs    = m_arv && arready;
        rb    = rvalid && (m_pend > 0);
        nack  = 1'b0;
        nerr  = 1'b0;
        ndata = '0;
        if (rb && !m_flush && cyc) begin
            if (rresp[1]) nerr = 1'b1;
            else begin
                nack  = 1'b1;
                ndata = rdata;
            end
        end
        if (acc && is_wr) nerr = 1'b1;
        pend_n = m_pend + int'(acc && !is_wr) - int'(rb);
        if (m_flush)         flush_n = !((m_pend == 0) && !m_arv);
        else if (m_pend > 0) flush_n = (rb && rresp[1]) || (!cyc && (pend_n != 0));
        else                 flush_n = 1'b0;

        @(posedge clk);
        if (hs) begin
            sq.push_back('{addr: m_araddr, resp: resp_for(m_araddr)});
            hs_cnt++;
        end
        if (rvalid) void'(sq.pop_front());
        if (acc && !is_wr) begin
            m_arv    = 1'b1;
            m_araddr = {addr, 2'b00};
        end else if (hs) begin
            m_arv = 1'b0;
        end
        m_pend      = pend_n;
        m_flush     = flush_n;
        last_accept = acc;
        cyc_cnt++;

        @(negedge clk);
        check("ack", ack, nack);
        check("err", err, nerr);
        if (nack) check("data", wb_data, ndata);
        ack_cnt += int'(nack);
        err_cnt += int'(nerr);
    endtask

    task automatic wb_req(input logic [WAW-1:0] a, input bit w);
        cyc  = 1'b1;
        stb  = 1'b1;
        addr = a;
        we   = w;
        last_accept = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (last_accept) break;
        end
        check("req_timeout", last_accept, 1);
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic drain(input int lim);
        r_en    = 1'b1;
        ar_rand = 1'b1;
        for (int i = 0; i < lim && (m_pend != 0 || m_flush || m_arv); i++) cycle();
        check("drain_timeout", {m_pend != 0, m_flush, m_arv}, 0);
        ar_rand = 1'b0;
    endtask

    task automatic do_reset();
        w_reset = 1'b1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0; rvalid = 1'b0; arready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        w_reset = 1'b0;
        m_arv = 1'b0; m_pend = 0; m_flush = 1'b0;
        check("rst_arvalid", arvalid, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_stall", stall, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, a, e, h;
        logic [WAW-1:0] wa;

        do_reset();
        check("arprot", arprot, 3'b000);
        check("rready", rready, 1);

        // Single read, minimum latency.
        ar_force = 1; r_en = 1; r_always = 1;
        wb_req(26'h100, 0);
        check("araddr_400", araddr, 28'h400);
        t = cyc_cnt; a = ack_cnt;
        for (int i = 0; i < 10 && ack_cnt == a; i++) cycle();
        check("lat_ack", cyc_cnt - t, 2);
        check("data_dead", wb_data, 32'hDEAD_BEEF);
        drain(50);

        // Eight back-to-back requests with R held off; the ninth must stall.
        r_en = 0; ar_force = 1; a = ack_cnt; t = cyc_cnt;
        for (int k = 0; k < 8; k++) wb_req(rand_addr(0), 0);
        check("b2b_cycles", cyc_cnt - t, 8);
        stb = 1; addr = rand_addr(0);
        repeat (3) cycle();
        check("ninth_held", last_accept, 0);
        check("ninth_stall", stall, 1);
        r_en = 1; r_always = 0;
        wb_req(addr, 0);
        drain(200);
        check("acks_nine", ack_cnt - a, 9);

        // AR stalled by the slave for five cycles.
        ar_force = 0; r_en = 1;
        wb_req(rand_addr(0), 0);
        h = hs_cnt; wa = rand_addr(0);
        stb = 1; addr = wa;
        repeat (5) cycle();
        check("ar_no_hs", hs_cnt - h, 0);
        ar_force = 1; t = cyc_cnt;
        wb_req(wa, 0);
        check("ar_one_hs", hs_cnt - h, 1);
        check("ar_b2b", cyc_cnt - t, 1);
        drain(100);

        // Error in the middle of three reads.
        ar_force = 1; r_en = 0; a = ack_cnt; e = err_cnt;
        wb_req(26'h0010, 0);
        wb_req(26'h3810, 0);
        wb_req(26'h0020, 0);
        r_en = 1; r_always = 1;
        drain(100);
        check("err3_acks", ack_cnt - a, 1);
        check("err3_errs", err_cnt - e, 1);
        cycle();

        // Master abandons the cycle with four reads outstanding.
        r_en = 0; r_always = 0; a = ack_cnt; e = err_cnt;
        for (int k = 0; k < 4; k++) wb_req(rand_addr(0), 0);
        cyc = 0;
        repeat (3) cycle();
        check("drop_stall", stall, 1);
        drain(200);
        check("drop_acks", ack_cnt - a, 0);
        check("drop_errs", err_cnt - e, 0);
        cyc = 1;
        cycle();

`ifdef WBRD2AXIL_WE_ERR_EN
        // Write behind two reads: waits for them, then errors without AR.
        r_en = 0; ar_force = 1;
        wb_req(rand_addr(0), 0);
        wb_req(rand_addr(0), 0);
        stb = 1; we = 1; addr = rand_addr(0);
        repeat (3) cycle();
        check("we_held", last_accept, 0);
        r_en = 1; h = hs_cnt; e = err_cnt;
        wb_req(addr, 1);
        check("we_err", err_cnt - e, 1);
        check("we_no_arvalid", arvalid, 0);
        cycle();
        check("we_no_hs", hs_cnt - h, 0);
        drain(50);
`endif

        // Random bursts: random AR/R back-pressure, error region, cyc drops.
        r_en = 1; r_always = 0;
        for (int it = 0; it < 150; it++) begin
            ar_rand = 1; cyc = 1;
            for (int k = 0; k < int'($urandom_range(1, 10)); k++) wb_req(rand_addr(1), 0);
            if ($urandom_range(0, 3) == 0) cyc = 0;
            drain(400);
            cyc = 1;
        end

        // Reset with reads in flight; the late R beats must be ignored.
        ar_force = 1; r_en = 0; r_always = 0;
        for (int k = 0; k < 3; k++) wb_req(rand_addr(0), 0);
        cycle();
        do_reset();
        a = ack_cnt; e = err_cnt;
        r_en = 1; r_always = 1; ar_force = 1;
        for (int i = 0; i < 20 && sq.size() > 0; i++) cycle();
        check("late_drained", sq.size(), 0);
        check("late_acks", ack_cnt - a, 0);
        check("late_errs", err_cnt - e, 0);
        wb_req(26'h100, 0);
        drain(50);
        check("post_rst_ack", ack_cnt - a, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_wbrd2axil
